// File: rtl/carry_bypass_adder_pipe.sv
// Pipelined carry-bypass (carry-skip) adder/subtractor with a valid/ready stream
// interface. Each pipeline stage resolves BLKS_PER_STAGE skip blocks of BLK bits.
// A global stall freezes every stage whenever the output holds an unaccepted beat.
module carry_bypass_adder_pipe #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned BLK            = 4,
  parameter int unsigned BLKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SBITS = BLK * BLKS_PER_STAGE;
  localparam int unsigned L     = (SBITS == 0 || WIDTH < SBITS) ? 1 : WIDTH / SBITS;

  if (BLK == 0 || BLKS_PER_STAGE == 0 || WIDTH == 0 ||
      ((SBITS == 0) ? 1 : (WIDTH % SBITS)) != 0) begin : g_param_check
    $error("carry_bypass_adder_pipe: WIDTH must be a non-zero multiple of BLK*BLKS_PER_STAGE");
  end

  // Stage registers: operands (b already conditioned for subtract), partial sum,
  // running carry, carry into the MSB and beat valid.
  logic [WIDTH-1:0] a_q [L];
  logic [WIDTH-1:0] a_d [L];
  logic [WIDTH-1:0] b_q [L];
  logic [WIDTH-1:0] b_d [L];
  logic [WIDTH-1:0] s_q [L];
  logic [WIDTH-1:0] s_d [L];
  logic             c_q [L];
  logic             c_d [L];
  logic             m_q [L];
  logic             m_d [L];
  logic             v_q [L];
  logic             v_d [L];

  // Inputs to each stage's combinational block and its results.
  logic [WIDTH-1:0] src_a [L];
  logic [WIDTH-1:0] src_b [L];
  logic [WIDTH-1:0] src_s [L];
  logic             src_c [L];
  logic             src_v [L];
  logic [WIDTH-1:0] res_s [L];
  logic             res_c [L];
  logic             res_m [L];

  logic adv;
  logic unused_stage_bits;

  assign adv       = !v_q[L-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[L-1];
  assign sum       = s_q[L-1];
  assign cout      = c_q[L-1];
  assign ovf       = m_q[L-1] ^ c_q[L-1];

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [WIDTH-1:0]        s_loc;
    logic [BLKS_PER_STAGE:0] blk_c;

    if (k == 0) begin : g_src_in
      assign src_a[k] = a;
      assign src_b[k] = b ^ {WIDTH{sub}};
      assign src_s[k] = '0;
      assign src_c[k] = cin ^ sub;
      assign src_v[k] = in_valid;
    end else begin : g_src_reg
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_c[k] = c_q[k-1];
      assign src_v[k] = v_q[k-1];
    end

    assign blk_c[0] = src_c[k];

    for (genvar j = 0; j < BLKS_PER_STAGE; j++) begin : g_blk
      localparam int unsigned BASE = k * SBITS + j * BLK;
      logic [BLK:0]   rc;
      logic [BLK-1:0] pb;

      assign rc[0] = blk_c[j];
      for (genvar i = 0; i < BLK; i++) begin : g_bit
        assign pb[i]          = src_a[k][BASE+i] ^ src_b[k][BASE+i];
        assign rc[i+1]        = (src_a[k][BASE+i] & src_b[k][BASE+i]) | (pb[i] & rc[i]);
        assign s_loc[BASE+i]  = pb[i] ^ rc[i];
      end
      // Whole-block propagate forwards the incoming carry past the ripple chain.
      assign blk_c[j+1] = (&pb) ? blk_c[j] : rc[BLK];

      if (j == BLKS_PER_STAGE - 1) begin : g_top
        assign res_m[k] = rc[BLK-1];
      end
    end

    for (genvar n = 0; n < WIDTH; n++) begin : g_pass
      if ((n / SBITS) != k) begin : g_keep
        assign s_loc[n] = src_s[k][n];
      end
    end

    assign res_s[k] = s_loc;
    assign res_c[k] = blk_c[BLKS_PER_STAGE];
  end

  // Next state: every stage shifts forward on adv, otherwise all stages hold.
  always_comb begin
    for (int unsigned k = 0; k < L; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      m_d[k] = m_q[k];
      v_d[k] = v_q[k];
      if (adv) begin
        a_d[k] = src_a[k];
        b_d[k] = src_b[k];
        s_d[k] = res_s[k];
        c_d[k] = res_c[k];
        m_d[k] = res_m[k];
        v_d[k] = src_v[k];
      end
    end
  end

  // Stage registers with synchronous reset discarding every in-flight beat.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < L; k++) begin
      if (rst) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end else begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        m_q[k] <= m_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

  // Last-stage operands and intermediate MSB carries are never consumed.
  always_comb begin
    unused_stage_bits = 1'b0;
    for (int unsigned k = 0; k < L; k++) begin
      unused_stage_bits = unused_stage_bits ^ (^a_q[k]) ^ (^b_q[k]) ^ m_q[k];
    end
  end

endmodule
